// File: rtl/comb_tt_pkg.sv
`default_nettype none
// ============================================================================
// comb_tt_pkg : shared types and helpers for the truth-table capture block
// Revision    : 1.0
// ============================================================================
package comb_tt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      FINISH = 2'd2
   } tt_state_t;

   localparam int N_IN_DEFAULT = 4;

   function automatic int tt_width(input int n);
      return 2 ** n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/comb_truth_capture_settle_timer.sv
`default_nettype none
// ============================================================================
// settle_timer : loadable down-counter that stops at zero
// Revision     : 1.0
// ============================================================================
module settle_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] value,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (dec && (value != '0)) begin
         value <= value - 1'b1;
      end
   end

   assign zero = (value == '0);

endmodule
`default_nettype wire

// File: rtl/comb_truth_capture.sv
`default_nettype none
// ============================================================================
// comb_truth_capture : clocked truth-table scan of a combinational function
// Revision           : 1.0
// ============================================================================
module comb_truth_capture
   import comb_tt_pkg::*;
#(
   parameter int N_IN          = N_IN_DEFAULT,
   parameter int SETTLE_CYCLES = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 y_in,
   output logic [N_IN-1:0]      vec_out,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_out,
   output logic [N_IN:0]        mismatch_count,
   output logic                 match
);

   localparam int              W        = tt_width(N_IN);
   localparam int              TW       = $clog2(SETTLE_CYCLES + 1);
   localparam logic [TW-1:0]   RELOAD   = TW'(SETTLE_CYCLES - 1);
   localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

   tt_state_t       state;
   logic [N_IN-1:0] index;
   logic [W-1:0]    expected_q;

   logic            timer_load;
   logic            timer_dec;
   logic            timer_zero;
   logic [TW-1:0]   timer_value;
   logic            sample_now;
   logic            miss;

   assign sample_now = (state == SETTLE) && timer_zero;
   assign miss       = (y_in != expected_q[index]);
   assign timer_load = ((state == IDLE) && start) ||
                       (sample_now && (index != LAST_IDX));
   assign timer_dec  = (state == SETTLE) && (timer_value != '0);

   settle_timer #(
      .WIDTH (TW)
   ) u_settle_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (RELOAD),
      .dec        (timer_dec),
      .value      (timer_value),
      .zero       (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         index          <= '0;
         expected_q     <= '0;
         vec_out        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         table_out      <= '0;
         mismatch_count <= '0;
         match          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  expected_q     <= expected;
                  table_out      <= '0;
                  mismatch_count <= '0;
                  match          <= 1'b0;
                  index          <= '0;
                  vec_out        <= '0;
                  busy           <= 1'b1;
                  state          <= SETTLE;
               end
            end
            SETTLE: begin
               if (timer_zero) begin
                  table_out[index] <= y_in;
                  if (miss) begin
                     mismatch_count <= mismatch_count + 1'b1;
                  end
                  if (index == LAST_IDX) begin
                     // Final sample: match must fold in this last comparison.
                     match   <= (mismatch_count == '0) && !miss;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     vec_out <= '0;
                     state   <= FINISH;
                  end else begin
                     index   <= index + 1'b1;
                     vec_out <= index + 1'b1;
                  end
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_comb_truth_capture.sv
`default_nettype none
// ============================================================================
// tb_comb_truth_capture : randomized scans against a truth-table reference
// Revision              : 1.0
// ============================================================================
module tb_comb_truth_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a [2];
   logic        y_a     [2];
   logic        busy_a  [2];
   logic        done_a  [2];
   logic        match_a [2];
   logic [15:0] exp_a   [2];
   logic [15:0] tt_a    [2];
   logic [15:0] tab_a   [2];
   logic [3:0]  vec_a   [2];
   logic [4:0]  mc_a    [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // The function under test is modelled as a lookup of its own truth table.
   assign y_a[0] = tt_a[0][vec_a[0]];
   assign y_a[1] = tt_a[1][vec_a[1]];

   comb_truth_capture #(.N_IN(4), .SETTLE_CYCLES(10)) dut (
      .clk(clk), .rst(rst), .start(start_a[0]), .expected(exp_a[0]), .y_in(y_a[0]),
      .vec_out(vec_a[0]), .busy(busy_a[0]), .done(done_a[0]), .table_out(tab_a[0]),
      .mismatch_count(mc_a[0]), .match(match_a[0])
   );

   comb_truth_capture #(.N_IN(4), .SETTLE_CYCLES(1)) dut_fast (
      .clk(clk), .rst(rst), .start(start_a[1]), .expected(exp_a[1]), .y_in(y_a[1]),
      .vec_out(vec_a[1]), .busy(busy_a[1]), .done(done_a[1]), .table_out(tab_a[1]),
      .mismatch_count(mc_a[1]), .match(match_a[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      total++;
      if (obs !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, req);
      end
   endtask

   task automatic check_idle(input int inst, input string tag);
      check({tag, "_vec"},   vec_a[inst],   0);
      check({tag, "_busy"},  busy_a[inst],  0);
      check({tag, "_done"},  done_a[inst],  0);
      check({tag, "_tab"},   tab_a[inst],   0);
      check({tag, "_mc"},    mc_a[inst],    0);
      check({tag, "_match"}, match_a[inst], 0);
   endtask

   // Called at a negedge; start is presented in the cycle that follows.
   task automatic scan(input int inst, input int s, input logic [15:0] tt,
                       input logic [15:0] ex, input bit repulse, input int abort_vec);
      int errs;
      int last;
      int mm;
      errs = 0;
      last = 16 * s;
      mm   = $countones(tt ^ ex);
      tt_a[inst]    = tt;
      exp_a[inst]   = ex;
      start_a[inst] = 1'b1;
      @(negedge clk);
      start_a[inst] = 1'b0;
      check("start_tab",   tab_a[inst],   0);
      check("start_mc",    mc_a[inst],    0);
      check("start_match", match_a[inst], 0);
      for (int j = 0; j < last; j++) begin
         if (vec_a[inst] !== 4'(j / s) || busy_a[inst] !== 1'b1 || done_a[inst] !== 1'b0)
            errs++;
         if (abort_vec >= 0 && j == abort_vec * s + 2) begin
            check("pre_rst_vec", vec_a[inst], abort_vec);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_idle(inst, "abort");
            errs = 0;
            for (int k = 0; k < 2 * last; k++) begin
               @(negedge clk);
               if (done_a[inst] !== 1'b0 || busy_a[inst] !== 1'b0 || vec_a[inst] !== 4'd0)
                  errs++;
            end
            check("abort_quiet", errs, 0);
            return;
         end
         start_a[inst] = repulse && (j == 4 || j == 79);
         if (j == last / 3) exp_a[inst] = 16'($urandom);
         @(negedge clk);
      end
      start_a[inst] = 1'b0;
      check("scan_seq",   errs,          0);
      check("done_hi",    done_a[inst],  1);
      check("done_busy",  busy_a[inst],  0);
      check("done_vec",   vec_a[inst],   0);
      check("table",      tab_a[inst],   tt);
      check("mismatch",   mc_a[inst],    mm);
      check("match",      match_a[inst], (mm == 0));
      @(negedge clk);
      check("done_lo",    done_a[inst],  0);
      check("hold_table", tab_a[inst],   tt);
      check("hold_mc",    mc_a[inst],    mm);
      check("hold_match", match_a[inst], (mm == 0));
   endtask

   initial begin
      logic [15:0] t;
      start_a[0] = 1'b0;
      start_a[1] = 1'b0;
      exp_a[0]   = '0;
      exp_a[1]   = '0;
      tt_a[0]    = '0;
      tt_a[1]    = '0;
      repeat (3) @(negedge clk);
      check_idle(0, "reset0");
      check_idle(1, "reset1");
      rst = 1'b0;
      @(negedge clk);

      scan(0, 10, 16'h8000, 16'h8000, 1'b0, -1);
      scan(0, 10, 16'h6996, 16'h6996, 1'b0, -1);
      scan(0, 10, 16'h6996, 16'h6997, 1'b1, -1);
      scan(0, 10, 16'h5A3C, 16'h5A3C, 1'b0, 5);
      scan(0, 10, 16'hC3A5, 16'hC3A4, 1'b0, -1);

      scan(1, 1, 16'h00FF, 16'h00FF, 1'b0, -1);
      t = 16'($urandom);
      scan(1, 1, t, ~t, 1'b0, -1);
      for (int i = 0; i < 8; i++) begin
         t = 16'($urandom);
         scan(1, 1, t, t ^ 16'($urandom & $urandom & $urandom), 1'b0, -1);
      end
      for (int i = 0; i < 3; i++) begin
         t = 16'($urandom);
         scan(0, 10, t, t ^ 16'($urandom & $urandom), i == 1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
